// File: rtl/fifo_thresh_ctrl.sv
// Single-clock FIFO with run-time almost-full/almost-empty thresholds,
// hysteretic pause output and sticky overflow/underflow flags.
module fifo_thresh_ctrl #(
   parameter int DATA_SIZE = 6,
   parameter int ADDR_SIZE = 2,
   parameter int CNT_SIZE  = ADDR_SIZE + 1
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_SIZE-1:0] data_in,
   input  logic [CNT_SIZE-1:0]  af_thr,
   input  logic [CNT_SIZE-1:0]  ae_thr,
   input  logic                 err_clr,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 valid_out,
   output logic [CNT_SIZE-1:0]  data_count,
   output logic                 fifo_empty,
   output logic                 fifo_full,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 fifo_pause,
   output logic                 overflow_err,
   output logic                 underflow_err
);
   localparam int                  DEPTH     = 2 ** ADDR_SIZE;
   localparam logic [CNT_SIZE-1:0] DEPTH_CNT = CNT_SIZE'(DEPTH);

   typedef enum logic {RUN, PAUSE} pause_state_t;

   pause_state_t         state, state_next;
   logic [DATA_SIZE-1:0] mem [DEPTH];
   logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
   logic [CNT_SIZE-1:0]  count_next;
   logic                 push_ok, pop_ok;

   assign fifo_empty   = (data_count == '0);
   assign fifo_full    = (data_count == DEPTH_CNT);
   assign almost_full  = (data_count >= af_thr);
   assign almost_empty = (data_count <= ae_thr) && !fifo_empty;
   assign fifo_pause   = (state == PAUSE);

   // A push on a full FIFO is only safe when a pop frees the slot on the same edge.
   assign push_ok = push & (~fifo_full | pop);
   assign pop_ok  = pop & ~fifo_empty;

   always_comb begin
      // NOTE: default first so every path assigns count_next and no latch is inferred.
      count_next = data_count;
      if (push_ok && !pop_ok)
         count_next = data_count + CNT_SIZE'(1);
      else if (pop_ok && !push_ok)
         count_next = data_count - CNT_SIZE'(1);
   end

   // Pause looks at the post-edge occupancy; the almost-full side wins when thresholds overlap.
   always_comb begin
      state_next = state;
      if (count_next >= af_thr)
         state_next = PAUSE;
      else if (count_next <= ae_thr)
         state_next = RUN;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         state <= RUN;
      else
         state <= state_next;
   end

   // NOTE: storage has no reset; pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= data_in;
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         data_count    <= '0;
         data_out      <= '0;
         valid_out     <= 1'b0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + ADDR_SIZE'(1);
         if (pop_ok) begin
            rd_ptr   <= rd_ptr + ADDR_SIZE'(1);
            data_out <= mem[rd_ptr];
         end
         valid_out     <= pop_ok;
         data_count    <= count_next;
         overflow_err  <= (push & ~push_ok) | (overflow_err & ~err_clr);
         underflow_err <= (pop & ~pop_ok) | (underflow_err & ~err_clr);
      end
   end

endmodule

// File: tb/tb_fifo_thresh_ctrl.sv
// Self-checking bench for fifo_thresh_ctrl: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_fifo_thresh_ctrl;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset_L, push, pop, err_clr;
   logic [5:0] data_in, data_out;
   logic [2:0] af_thr, ae_thr, data_count;
   logic       valid_out, fifo_empty, fifo_full, almost_full, almost_empty;
   logic       fifo_pause, overflow_err, underflow_err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [5:0] q[$];
   logic [5:0] m_dout;
   logic       m_valid, m_pause, m_ovf, m_unf;

   fifo_thresh_ctrl #(.DATA_SIZE(6), .ADDR_SIZE(2), .CNT_SIZE(3)) dut (
      .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
      .af_thr(af_thr), .ae_thr(ae_thr), .err_clr(err_clr), .data_out(data_out),
      .valid_out(valid_out), .data_count(data_count), .fifo_empty(fifo_empty),
      .fifo_full(fifo_full), .almost_full(almost_full), .almost_empty(almost_empty),
      .fifo_pause(fifo_pause), .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      q.delete();
      m_dout = '0; m_valid = 0; m_pause = 0; m_ovf = 0; m_unf = 0;
   endtask

   // Drive one cycle of inputs, advance past the edge, update the model.
   task automatic step(input logic p, input logic po, input logic [5:0] d, input logic clr);
      logic wok, pok;
      int   n;
      push = p; pop = po; data_in = d; err_clr = clr;
      @(posedge clk);
      pok = po && (q.size() != 0);
      wok = p && ((q.size() != DEPTH) || po);
      m_valid = pok;
      if (pok) m_dout = q.pop_front();
      if (wok) q.push_back(d);
      m_ovf = (p && !wok) || (m_ovf && !clr);
      m_unf = (po && !pok) || (m_unf && !clr);
      n = q.size();
      if (n >= int'(af_thr)) m_pause = 1;
      else if (n <= int'(ae_thr)) m_pause = 0;
      #1;
      push = 0; pop = 0; err_clr = 0;
   endtask

   task automatic test_reset();
      reset_L = 0; push = 0; pop = 0; err_clr = 0; data_in = '0;
      af_thr = 3'd3; ae_thr = 3'd1;
      model_reset();
      repeat (3) @(posedge clk);
      #2 reset_L = 1;
      step(0, 0, '0, 0);
      checks++; if (data_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", data_count); end
      checks++; if ({fifo_empty, fifo_full, almost_full, almost_empty} !== 4'b1000) begin errors++; $display("FAIL reset_status: got %b expected 1000", {fifo_empty, fifo_full, almost_full, almost_empty}); end
      checks++; if ({fifo_pause, overflow_err, underflow_err, valid_out} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {fifo_pause, overflow_err, underflow_err, valid_out}); end
      checks++; if (data_out !== 6'd0) begin errors++; $display("FAIL reset_dout: got %0h expected 0", data_out); end
   endtask

   task automatic test_fill_drain();
      af_thr = 3'd3; ae_thr = 3'd1;
      for (int i = 1; i <= 4; i++) begin
         step(1, 0, 6'(i), 0);
         checks++; if (data_count !== 3'(i)) begin errors++; $display("FAIL fill_count %0d: got %0d expected %0d", i, data_count, i); end
         checks++; if ({fifo_full, almost_full, fifo_pause} !== {i == 4, i >= 3, i >= 3}) begin errors++; $display("FAIL fill_status %0d: got %b expected %b", i, {fifo_full, almost_full, fifo_pause}, {i == 4, i >= 3, i >= 3}); end
      end
      for (int k = 1; k <= 4; k++) begin
         step(0, 1, '0, 0);
         checks++; if ({valid_out, data_out} !== {1'b1, 6'(k)}) begin errors++; $display("FAIL drain_data %0d: got %b/%0h expected 1/%0h", k, valid_out, data_out, k); end
         checks++; if (data_count !== 3'(4 - k)) begin errors++; $display("FAIL drain_count %0d: got %0d expected %0d", k, data_count, 4 - k); end
         checks++; if (fifo_pause !== (4 - k >= 2)) begin errors++; $display("FAIL drain_pause %0d: got %b expected %b", k, fifo_pause, (4 - k >= 2)); end
      end
      step(0, 0, '0, 0);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL drain_valid_drop: got %b expected 0", valid_out); end
   endtask

   task automatic test_push_pop_full();
      logic [5:0] oldest;
      for (int i = 0; i < 4; i++) step(1, 0, 6'($urandom), 0);
      oldest = q[0];
      step(1, 1, 6'h2A, 0);
      checks++; if (data_count !== 3'd4) begin errors++; $display("FAIL full_pp_count: got %0d expected 4", data_count); end
      checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL full_pp_ovf: got %b expected 0", overflow_err); end
      checks++; if ({valid_out, data_out} !== {1'b1, oldest}) begin errors++; $display("FAIL full_pp_data: got %b/%0h expected 1/%0h", valid_out, data_out, oldest); end
      step(1, 0, 6'h11, 0);
      checks++; if ({overflow_err, data_count} !== {1'b1, 3'd4}) begin errors++; $display("FAIL full_push_ovf: got %b/%0d expected 1/4", overflow_err, data_count); end
   endtask

   task automatic test_underflow();
      logic [5:0] exp_d;
      for (int i = 0; i < 4; i++) begin
         exp_d = q[0];
         step(0, 1, '0, 0);
         checks++; if (data_out !== exp_d) begin errors++; $display("FAIL uf_drain %0d: got %0h expected %0h", i, data_out, exp_d); end
      end
      step(0, 1, '0, 0);
      checks++; if ({underflow_err, valid_out} !== 2'b10) begin errors++; $display("FAIL uf_set: got %b expected 10", {underflow_err, valid_out}); end
      step(0, 0, '0, 1);
      checks++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("FAIL uf_clear: got %b expected 00", {overflow_err, underflow_err}); end
      step(1, 1, 6'h33, 0);
      checks++; if ({data_count, underflow_err, valid_out} !== {3'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL uf_pp_empty: got %0d/%b/%b expected 1/1/0", data_count, underflow_err, valid_out); end
      step(1, 0, 6'h05, 1);
      checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL uf_clear2: got %b expected 0", underflow_err); end
      step(0, 1, '0, 0);
      step(0, 1, '0, 1);
      checks++; if ({data_out, underflow_err} !== {6'h05, 1'b0}) begin errors++; $display("FAIL uf_order: got %0h/%b expected 05/0", data_out, underflow_err); end
      step(0, 1, '0, 1);
      checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_set_wins: got %b expected 1", underflow_err); end
   endtask

   task automatic test_wrap();
      step(0, 0, '0, 1);
      step(1, 0, 6'h20, 0);
      step(1, 0, 6'h21, 0);
      for (int i = 2; i < 6; i++) begin
         step(1, 1, 6'(6'h20 + i), 0);
         checks++; if ({valid_out, data_out, data_count} !== {1'b1, 6'(6'h20 + i - 2), 3'd2}) begin errors++; $display("FAIL wrap %0d: got %b/%0h/%0d expected 1/%0h/2", i, valid_out, data_out, data_count, 6'h20 + i - 2); end
      end
      for (int i = 0; i < 2; i++) begin
         step(0, 1, '0, 0);
         checks++; if ({data_out, data_count} !== {6'(6'h24 + i), 3'(1 - i)}) begin errors++; $display("FAIL wrap_tail %0d: got %0h/%0d expected %0h/%0d", i, data_out, data_count, 6'h24 + i, 1 - i); end
      end
   endtask

   task automatic test_random();
      logic p, po, clr;
      int   n;
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) begin
            af_thr = 3'($urandom_range(0, 7));
            ae_thr = 3'($urandom_range(0, 7));
         end
         p = ($urandom_range(0, 99) < 55);
         po = ($urandom_range(0, 99) < 45);
         clr = ($urandom_range(0, 99) < 8);
         step(p, po, 6'($urandom), clr);
         n = q.size();
         checks++; if (data_count !== 3'(n)) begin errors++; $display("FAIL rand_count cyc %0d: got %0d expected %0d", i, data_count, n); end
         checks++; if ({fifo_empty, fifo_full, almost_full, almost_empty} !== {n == 0, n == DEPTH, n >= int'(af_thr), n <= int'(ae_thr) && n != 0}) begin errors++; $display("FAIL rand_status cyc %0d: got %b expected %b", i, {fifo_empty, fifo_full, almost_full, almost_empty}, {n == 0, n == DEPTH, n >= int'(af_thr), n <= int'(ae_thr) && n != 0}); end
         checks++; if ({fifo_pause, overflow_err, underflow_err, valid_out} !== {m_pause, m_ovf, m_unf, m_valid}) begin errors++; $display("FAIL rand_flags cyc %0d: got %b expected %b", i, {fifo_pause, overflow_err, underflow_err, valid_out}, {m_pause, m_ovf, m_unf, m_valid}); end
         checks++; if (data_out !== m_dout) begin errors++; $display("FAIL rand_dout cyc %0d: got %0h expected %0h", i, data_out, m_dout); end
      end
   endtask

   task automatic test_async_reset();
      af_thr = 3'd2; ae_thr = 3'd0;
      step(0, 0, '0, 1);
      while (q.size() != 0) step(0, 1, '0, 0);
      step(0, 1, '0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 6'(6'h0A + i), 0);
      step(0, 1, '0, 0);
      step(1, 0, 6'h0F, 0);
      #2 reset_L = 0;
      model_reset();
      #1;
      checks++; if ({data_count, data_out} !== {3'd0, 6'd0}) begin errors++; $display("FAIL arst_regs: got %0d/%0h expected 0/0", data_count, data_out); end
      checks++; if ({fifo_empty, fifo_full, almost_full, almost_empty, fifo_pause, overflow_err, underflow_err, valid_out} !== 8'b1000_0000) begin errors++; $display("FAIL arst_flags: got %b expected 10000000", {fifo_empty, fifo_full, almost_full, almost_empty, fifo_pause, overflow_err, underflow_err, valid_out}); end
      #1 reset_L = 1;
      step(1, 0, 6'h15, 0);
      step(0, 1, '0, 0);
      checks++; if ({valid_out, data_out, data_count} !== {1'b1, 6'h15, 3'd0}) begin errors++; $display("FAIL arst_newdata: got %b/%0h/%0d expected 1/15/0", valid_out, data_out, data_count); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_push_pop_full();
      test_underflow();
      test_wrap();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
